// File: rtl/buffered_transmit_pkg.sv
// Shared UART definitions: transmitter state encoding, frame constants and the
// bit-period calculation, shared with the receive block.
package buffered_transmit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;

  // Clock cycles per line bit; integer truncation of FREQ/BAUD.
  function automatic int unsigned calc_div(input int unsigned freq, input int unsigned baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/buffered_transmit_sync_fifo.sv
// Single-clock FIFO with occupancy count; full/empty are derived from the count
// so the pointers can wrap freely.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      cnt
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_q[rd_q];
  assign cnt     = cnt_q;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_ok) wr_d = wr_q + AW'(1);
    if (pop_ok)  rd_d = rd_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/buffered_transmit.sv
// UART 8N1 transmitter fed from a byte FIFO; frames are sent back-to-back
// while the FIFO holds data.
module buffered_transmit
  import buffered_transmit_pkg::*;
#(
  parameter int BAUD  = 9600,
  parameter int FREQ  = 12000000,
  parameter int DEPTH = 16,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stb,
  input  logic [7:0]    dat,
  output logic          rdy,
  output logic          txd,
  output logic          busy,
  output logic [CW-1:0] cnt,
  output tx_state_e     dbg_state
);

  localparam int DIV  = int'(calc_div(FREQ, BAUD));
  localparam int BW   = $clog2(DIV);
  localparam int BITW = $clog2(DATA_BITS);

  // Handshake: a byte transfers on every clk edge where stb && rdy; rdy is a
  // registered copy of "FIFO not full after this edge", low during reset.
  tx_state_e       state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [BITW-1:0] bit_q, bit_d;
  logic [7:0]      sr_q, sr_d;
  logic            txd_q, txd_d;
  logic            rdy_q, rdy_d;
  logic            push, pop;
  logic            baud_end;
  logic [7:0]      fifo_dout;
  logic            fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_cnt, cnt_after;

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (dat),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .cnt   (fifo_cnt)
  );

  assign push      = stb && rdy_q && !fifo_full;
  assign cnt_after = fifo_cnt + CW'(push) - CW'(pop);
  assign rdy_d     = (cnt_after != CW'(DEPTH));
  assign baud_end  = (baud_q == BW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      txd_q   <= 1'b1;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      txd_q   <= txd_d;
      rdy_q   <= rdy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    txd_d   = txd_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        txd_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          sr_d    = fifo_dout;
          txd_d   = 1'b0;
          baud_d  = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          txd_d   = sr_q[0];
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      ST_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == BITW'(DATA_BITS - 1)) begin
            bit_d   = '0;
            txd_d   = 1'b1;
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + BITW'(1);
            sr_d  = sr_q >> 1;
            txd_d = sr_q[1];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      ST_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q != BITW'(STOP_BITS - 1)) begin
            bit_d = bit_q + BITW'(1);
          end else if (!fifo_empty) begin
            // Chain straight into the next start bit so frames stay contiguous.
            pop     = 1'b1;
            sr_d    = fifo_dout;
            txd_d   = 1'b0;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != ST_IDLE) || (fifo_cnt != '0);
    txd       = txd_q;
    rdy       = rdy_q;
    cnt       = fifo_cnt;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_buffered_transmit.sv
// Bench for buffered_transmit at DIV=4, DEPTH=4: directed pushes feed an
// expected-byte queue that a line monitor decodes txd against.
module tb_buffered_transmit;
  import buffered_transmit_pkg::*;

  localparam int BAUD  = 1;
  localparam int FREQ  = 4;
  localparam int DEPTH = 4;
  localparam int DIV   = 4;
  localparam int FRAME = 10 * DIV;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          stb = 1'b0;
  logic [7:0]    dat = 8'h00;
  logic          rdy;
  logic          txd;
  logic          busy;
  logic [CW-1:0] cnt;
  tx_state_e     dbg_state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] exp_q[$];
  int         start_q[$];

  buffered_transmit #(.BAUD(BAUD), .FREQ(FREQ), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .stb       (stb),
    .dat       (dat),
    .rdy       (rdy),
    .txd       (txd),
    .busy      (busy),
    .cnt       (cnt),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Leaves the caller #1 after the edge whose index is e.
  task automatic wait_edge(input int e);
    while (cyc < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one byte until accepted; returns the accepting edge index.
  task automatic push_byte(input logic [7:0] b, output int acc);
    logic r;
    int   n;
    stb = 1'b1;
    dat = b;
    acc = -1;
    n   = 0;
    while (acc < 0 && n < 300) begin
      r = rdy;
      @(posedge clk);
      #1;
      n++;
      if (r) acc = cyc;
    end
    stb = 1'b0;
    if (acc < 0) chk("push_timeout", 32'd0, 32'd1);
    else exp_q.push_back(b);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", 32'(busy), 32'd0);
  endtask

  // ---------------- scoreboard / line monitor ----------------
  initial begin
    logic [9:0] bits;
    logic       aborted;
    logic       stable;
    logic [7:0] want;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && txd === 1'b0) begin
        start_q.push_back(cyc);
        bits    = '0;
        aborted = 1'b0;
        stable  = 1'b1;
        for (int b = 0; b < 10 && !aborted; b++) begin
          for (int s = 0; s < DIV && !aborted; s++) begin
            if (b != 0 || s != 0) @(negedge clk);
            if (rst !== 1'b1) aborted = 1'b1;
            else if (s == 0) bits[b] = txd;
            else if (txd !== bits[b]) stable = 1'b0;
          end
        end
        if (!aborted) begin
          chk("bit_period_stable", 32'(stable), 32'd1);
          chk("stop_bit", 32'(bits[9]), 32'd1);
          if (exp_q.size() == 0) begin
            chk("unexpected_byte", 32'(bits[8:1]), 32'h100);
          end else begin
            want = exp_q.pop_front();
            chk("rx_byte", 32'(bits[8:1]), 32'(want));
          end
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int acc0, acc4, acc5, acc_a, acc_b, acc_c, acc_d, lows;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_rdy", 32'(rdy), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rdy_during_release", 32'(rdy), 32'd0);
    @(negedge clk);
    chk("rdy_after_release", 32'(rdy), 32'd1);

    // Single byte 0xA5: latency, cnt, busy fall
    push_byte(8'hA5, acc0);
    @(negedge clk);
    chk("single_cnt_after_push", 32'(cnt), 32'd1);
    chk("single_txd_still_idle", 32'(txd), 32'd1);
    chk("single_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("single_cnt_after_pop", 32'(cnt), 32'd0);
    chk("single_txd_start", 32'(txd), 32'd0);
    chk("single_state_start", 32'(dbg_state), 32'(ST_START));
    wait_edge(acc0 + 4);
    @(negedge clk);
    chk("single_start_last", 32'(txd), 32'd0);
    wait_edge(acc0 + 5);
    @(negedge clk);
    chk("single_bit0", 32'(txd), 32'd1);
    wait_edge(acc0 + 40);
    @(negedge clk);
    chk("single_busy_in_stop", 32'(busy), 32'd1);
    wait_edge(acc0 + 41);
    @(negedge clk);
    chk("single_busy_fall", 32'(busy), 32'd0);
    wait_idle();

    // Burst of 6 into a 4-deep FIFO, with an ignored strobe while full
    start_q.delete();
    push_byte(8'h00, acc0);
    push_byte(8'h01, acc4);
    push_byte(8'h02, acc4);
    push_byte(8'h03, acc4);
    push_byte(8'h04, acc4);
    chk("burst_back_to_back", 32'(acc4 - acc0), 32'd4);
    @(negedge clk);
    chk("burst_full_cnt", 32'(cnt), 32'd4);
    chk("burst_full_rdy", 32'(rdy), 32'd0);
    stb = 1'b1;
    dat = 8'hFF;
    repeat (6) @(negedge clk);
    stb = 1'b0;
    chk("ignored_cnt", 32'(cnt), 32'd4);
    push_byte(8'h05, acc5);
    chk("burst_stall_release", 32'(acc5 - acc0), 32'd42);
    wait_idle();
    chk("burst_frames", 32'(start_q.size()), 32'd6);
    if (start_q.size() > 0) chk("burst_first_start", 32'(start_q[0]), 32'(acc0 + 1));
    for (int i = 1; i < start_q.size(); i++)
      chk("burst_contiguous", 32'(start_q[i] - start_q[i-1]), 32'(FRAME));

    // Push on the STOP->START pop edge with cnt=2
    push_byte(8'h3C, acc_a);
    push_byte(8'hC3, acc_b);
    push_byte(8'h5A, acc_c);
    wait_edge(acc_a + 40);
    @(negedge clk);
    chk("simul_cnt_before", 32'(cnt), 32'd2);
    push_byte(8'h96, acc_d);
    chk("simul_push_edge", 32'(acc_d - acc_a), 32'd41);
    @(negedge clk);
    chk("simul_cnt_after", 32'(cnt), 32'd2);
    chk("simul_state", 32'(dbg_state), 32'(ST_START));
    wait_idle();

    // Reset mid-frame during data bit 3 with two bytes queued
    push_byte(8'hE7, acc_a);
    push_byte(8'h18, acc_b);
    push_byte(8'h81, acc_c);
    wait_edge(acc_a + 18);
    @(negedge clk);
    chk("midrst_cnt_before", 32'(cnt), 32'd2);
    chk("midrst_state_before", 32'(dbg_state), 32'(ST_DATA));
    rst = 1'b0;
    @(posedge clk);
    #1 exp_q.delete();
    @(negedge clk);
    chk("midrst_txd", 32'(txd), 32'd1);
    chk("midrst_cnt", 32'(cnt), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rdy", 32'(rdy), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_rdy_release", 32'(rdy), 32'd1);
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    chk("midrst_line_idle", 32'(lows), 32'd0);
    chk("midrst_busy_idle", 32'(busy), 32'd0);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
